// File: rtl/mux64_shift_add_seq.sv
// Sequential shift-add multiplier controller: walks a 64:1 bit-select mux across B
// and accumulates A << sel for each selected one, skipping acc_lvl low bits of B.
module mux64_shift_add_seq #(
   parameter int WA = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WA-1:0]    a_in,
   input  logic [63:0]      b_in,
   input  logic [5:0]       acc_lvl,
   input  logic             flush,
   output logic [63:0]      mux_a,
   output logic [5:0]       mux_sel,
   input  logic             mux_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WA+63:0]   product
);

   localparam int PW = WA + 64;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [WA-1:0]   a_q;
   logic [63:0]     mux_a_q;
   logic [5:0]      mux_sel_q;
   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   acc_d;
   logic [PW-1:0]   product_q;
   logic            out_valid_q;
   logic [PW-1:0]   a_ext;

   assign a_ext = {{64{1'b0}}, a_q};

   // Accumulator including this cycle's partial product; the shift stays within PW bits.
   always_comb begin
      acc_d = acc_q;
      if (mux_y) begin
         acc_d = acc_q + (a_ext << mux_sel_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         mux_a_q     <= '0;
         mux_sel_q   <= '0;
         acc_q       <= '0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= S_IDLE;
         mux_sel_q   <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q       <= a_in;
                  mux_a_q   <= b_in;
                  mux_sel_q <= acc_lvl;
                  acc_q     <= '0;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               if (mux_sel_q == 6'd63) begin
                  product_q   <= acc_d;
                  out_valid_q <= 1'b1;
                  mux_sel_q   <= '0;
                  state_q     <= S_DONE;
               end else begin
                  mux_sel_q <= mux_sel_q + 6'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               mux_sel_q   <= '0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mux_a     = mux_a_q;
   assign mux_sel   = mux_sel_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;

endmodule

// File: tb/tb_mux64_shift_add_seq.sv
// Directed bench for mux64_shift_add_seq: a transaction-level model (product by
// plain multiplication) is compared against the DUT on every falling edge.
module tb_mux64_shift_add_seq;

   localparam int WA = 16;
   localparam int PW = WA + 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WA-1:0] a_in = '0;
   logic [63:0]   b_in = '0;
   logic [5:0]    acc_lvl = '0;
   logic          flush = 1'b0;
   logic [63:0]   mux_a;
   logic [5:0]    mux_sel;
   logic          mux_y;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] product;

   int checks = 0;
   int errors = 0;

   mux64_shift_add_seq #(.WA(WA)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .acc_lvl   (acc_lvl),
      .flush     (flush),
      .mux_a     (mux_a),
      .mux_sel   (mux_sel),
      .mux_y     (mux_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   // The 64:1 bit-select mux the sequencer drives.
   assign mux_y = mux_a[mux_sel];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] ref_prod(input logic [WA-1:0] a, input logic [63:0] b, input int lvl);
      logic [63:0] kept;
      kept = b & ({64{1'b1}} << lvl);
      return PW'(a) * PW'(kept);
   endfunction

   // Transaction-level model: phase 0 idle, 1 scanning, 2 holding result.
   int            m_phase = 0;
   int            m_sel = 0;
   logic [WA-1:0] m_a = '0;
   logic [63:0]   m_b = '0;
   int            m_lvl = 0;
   logic [PW-1:0] m_prod = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_sel   <= 0;
         m_b     <= '0;
         m_prod  <= '0;
      end else if (flush) begin
         m_phase <= 0;
         m_sel   <= 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               m_a     <= a_in;
               m_b     <= b_in;
               m_lvl   <= int'(acc_lvl);
               m_sel   <= int'(acc_lvl);
               m_phase <= 1;
            end
            1: if (m_sel == 63) begin
               m_prod  <= ref_prod(m_a, m_b, m_lvl);
               m_sel   <= 0;
               m_phase <= 2;
            end else begin
               m_sel <= m_sel + 1;
            end
            default: if (out_ready) m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_in_ready", PW'(in_ready), PW'(m_phase == 0));
         check("cyc_out_valid", PW'(out_valid), PW'(m_phase == 2));
         check("cyc_mux_sel", PW'(mux_sel), PW'(m_sel));
         check("cyc_mux_a", PW'(mux_a), PW'(m_b));
         check("cyc_product", product, m_prod);
      end
   end

   // Issue one operation, measure accept-to-out_valid edges, then hold for bp cycles.
   task automatic run_op(input logic [WA-1:0] a, input logic [63:0] b, input logic [5:0] lvl,
                         input logic [PW-1:0] exp_p, input int bp, input bit pulse_in);
      int lat;
      in_valid = 1'b1; a_in = a; b_in = b; acc_lvl = lvl;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("accept_sel", PW'(mux_sel), PW'(lvl));
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", PW'(lat), PW'(64 - int'(lvl)));
      check("product_lit", product, exp_p);
      $display("txn a=0x%0h b=0x%0h lvl=%0d product=0x%0h latency=%0d", a, b, lvl, product, lat);
      for (int i = 0; i < bp; i++) begin
         if (pulse_in && i == 2) begin
            in_valid = 1'b1; a_in = ~a; b_in = ~b; acc_lvl = 6'd5;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         check("bp_out_valid", PW'(out_valid), PW'(1));
         check("bp_in_ready", PW'(in_ready), PW'(0));
         check("bp_product", product, exp_p);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_in_ready", PW'(in_ready), PW'(1));
      check("release_out_valid", PW'(out_valid), PW'(0));
   endtask

   task automatic wait_sel(input logic [5:0] target);
      int n;
      n = 0;
      while (mux_sel != target && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_sel", PW'(mux_sel), PW'(target));
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("rst_mux_sel", PW'(mux_sel), '0);
      check("rst_mux_a", PW'(mux_a), '0);
      check("rst_product", product, '0);
      check("rst_out_valid", PW'(out_valid), '0);
      check("rst_in_ready", PW'(in_ready), PW'(1));
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'd3, 64'h5, 6'd0, 80'd15, 0, 1'b0);
      run_op(16'hFFFF, {64{1'b1}}, 6'd0, 80'hFFFE_FFFF_FFFF_FFFF_0001, 0, 1'b0);
      run_op(16'd1, 64'h25, 6'd1, 80'h24, 0, 1'b0);
      run_op(16'd1, 64'h25, 6'd3, 80'h20, 0, 1'b0);
      run_op(16'd2, {64{1'b1}}, 6'd63, 80'h1_0000_0000_0000_0000, 0, 1'b0);
      run_op(16'd7, 64'h9, 6'd0, 80'd63, 5, 1'b1);

      // Abort by flush mid-scan: product must keep the previous result.
      in_valid = 1'b1; a_in = 16'd9; b_in = 64'hFF; acc_lvl = 6'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_sel(6'd10);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_in_ready", PW'(in_ready), PW'(1));
      check("flush_mux_sel", PW'(mux_sel), '0);
      check("flush_out_valid", PW'(out_valid), '0);
      check("flush_product", product, 80'd63);
      repeat (70) @(posedge clk);
      #1;
      check("flush_no_out", PW'(out_valid), '0);

      // Asynchronous reset mid-scan zeroes outputs without waiting for a clock.
      in_valid = 1'b1; a_in = 16'd11; b_in = 64'hF0F0; acc_lvl = 6'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_sel(6'd20);
      rst_n = 1'b0;
      #1;
      check("arst_mux_sel", PW'(mux_sel), '0);
      check("arst_mux_a", PW'(mux_a), '0);
      check("arst_product", product, '0);
      check("arst_out_valid", PW'(out_valid), '0);
      check("arst_in_ready", PW'(in_ready), PW'(1));
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'd5, 64'h3, 6'd0, 80'd15, 0, 1'b0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mux64_shift_add_seq.md
Name: mux64_shift_add_seq

Overview:
- Sequential shift-add controller for the 64:1 bit-select mux.
- Scans the mux select across a 64-bit multiplier operand B, one bit per cycle.
- Accumulates A << sel for every selected '1' bit.
- Accuracy control: a programmable number of B's low bits is skipped, trading accuracy for latency. This is the sequencer that drives the mux in the approximate multiplier datapath.

Parameters:
- WA, 16, width of multiplicand A; product width is WA+64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  high when able to accept operands
- a_in  input  WA  multiplicand A
- b_in  input  64  multiplier B
- acc_lvl  input  6  number of B LSBs skipped (0 = exact)
- flush  input  1  synchronous abort, returns to IDLE
- mux_a  output  64  data input to the 64:1 mux (registered copy of B)
- mux_sel  output  6  select to the mux
- mux_y  input  1  mux output; purely combinational, equal to mux_a[mux_sel] in the same cycle
- out_valid  output  1  product available
- out_ready  input  1  consumer accepts product
- product  output  WA+64  result, zero-extended, no overflow possible

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=IDLE, mux_a=0, mux_sel=0, product=0, out_valid=0.
  - Internal accumulator and A register cleared.
  - in_ready=1 once in IDLE.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE), registered.
- IDLE, on in_valid at a clock edge:
  - Captures a_in into A register, b_in into mux_a, acc_lvl into mux_sel.
  - Clears accumulator; moves to RUN.
  - in_valid with in_ready low is ignored; no queuing.
- RUN, each cycle:
  - If mux_y=1, accumulator += {64'b0, A} << mux_sel, at full WA+64 width.
  - If mux_sel==63, go to DONE and load product with the final accumulator value, including this cycle's add.
  - Otherwise mux_sel += 1.
  - mux_sel never wraps past 63.
- RUN lasts exactly 64-acc_lvl cycles. out_valid rises on the edge ending the last RUN cycle, i.e. 64-acc_lvl edges after the accept edge.
- DONE:
  - product and out_valid held stable until out_ready=1 at an edge; then go to IDLE and clear out_valid.
  - product holds its last value in IDLE.
  - mux_sel returns to 0 in IDLE and DONE; mux_a holds until the next accept.
- acc_lvl=63: single RUN cycle, only B[63] examined. acc_lvl=0: exact product.
- Result: product = A * (B with bits [acc_lvl-1:0] forced to 0).
- flush=1 at an edge in any state:
  - Goes to IDLE, out_valid=0, mux_sel=0; accumulator cleared.
  - product is not updated.
  - flush has priority over accept and over out_ready.
- in_valid and out_ready are never both acted on in one cycle: DONE→IDLE costs one cycle, and the next accept happens in IDLE.
- Reset asserted mid-RUN or DONE: operation discarded with no output. After release, the block behaves as freshly reset.
- No combinational path from in_valid or out_ready to any output other than through state.

Test Plan:
1. A=3, B=0x5, acc_lvl=0 → mux_sel steps 0..63 over 64 RUN cycles; out_valid 64 edges after accept; product=15; after out_ready=1, in_ready=1 next cycle.
2. A=0xFFFF, B=all ones, acc_lvl=0 → product=0xFFFE_FFFF_FFFF_FFFF_0001.
3. A=1, B=0x25: with acc_lvl=1 → product=0x24 after 63 RUN cycles; with acc_lvl=3 → product=0x20 after 61 RUN cycles.
4. A=2, B=all ones, acc_lvl=63 → 1 RUN cycle with mux_sel=63; product=0x1_0000_0000_0000_0000.
5. Backpressure: out_ready held low 5 cycles in DONE, with in_valid pulsed → product/out_valid stable, in_ready=0, pulse ignored; out_ready=1 → IDLE next cycle.
6. Abort: flush=1 at mux_sel=10 → IDLE next cycle, out_valid never rises, product unchanged. rst_n low at mux_sel=20 → immediate zeroing of outputs. After release, A=5, B=0x3, acc_lvl=0 → product=15.
